// File: rtl/seq_alu.sv
// seq_alu: registered ALU (ADD/SUB/AND/OR/EOR/LSL/LSR/MUL) behind a Start/Done handshake.
// Define SEQ_ALU_MUL_EN to build the shift-add multiplier; otherwise opcode 111 returns zero in one cycle.
module seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Start,
  input  logic [2:0]       ALUControl,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] ALUResult,
  output logic [3:0]       ALUFlag
);
  localparam int SHW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
  state_t state;

  logic [SHW-1:0]   shamt;
  logic [WIDTH:0]   wide;
  logic [WIDTH-1:0] res;
  logic             carry;
  logic             ovf;
  logic [3:0]       flags;
  logic             accept;
  logic             start_mul;

  assign shamt  = SrcB[SHW-1:0];
  assign accept = Start && (state != MUL);
  assign flags  = {res[WIDTH-1], res == '0, carry, ovf};

  // Shifts use a one-bit extension so the last bit shifted out lands in wide[WIDTH] or wide[0].
  always_comb begin
    wide  = '0;
    res   = '0;
    carry = 1'b0;
    ovf   = 1'b0;
    case (ALUControl)
      3'b000: begin
        wide  = {1'b0, SrcA} + {1'b0, SrcB};
        res   = wide[WIDTH-1:0];
        carry = wide[WIDTH];
        ovf   = (SrcA[WIDTH-1] == SrcB[WIDTH-1]) && (res[WIDTH-1] != SrcA[WIDTH-1]);
      end
      3'b001: begin
        wide  = {1'b0, SrcA} - {1'b0, SrcB};
        res   = wide[WIDTH-1:0];
        carry = wide[WIDTH];
        ovf   = (SrcA[WIDTH-1] != SrcB[WIDTH-1]) && (res[WIDTH-1] != SrcA[WIDTH-1]);
      end
      3'b010: res = SrcA & SrcB;
      3'b011: res = SrcA | SrcB;
      3'b100: res = SrcA ^ SrcB;
      3'b101: begin
        wide  = {1'b0, SrcA} << shamt;
        res   = wide[WIDTH-1:0];
        carry = wide[WIDTH];
      end
      3'b110: begin
        wide  = {SrcA, 1'b0} >> shamt;
        res   = wide[WIDTH:1];
        carry = wide[0];
      end
      default: res = '0;
    endcase
  end

`ifdef SEQ_ALU_MUL_EN
  localparam logic [SHW:0] CNT_INIT = (SHW+1)'(WIDTH);
  localparam logic [SHW:0] CNT_ONE  = (SHW+1)'(1);

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic [SHW:0]     count;

  assign start_mul = (ALUControl == 3'b111);
  assign acc_next  = mplier[0] ? (acc + mcand) : acc;
`else
  assign start_mul = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      ALUResult <= '0;
      ALUFlag   <= 4'b0100;
`ifdef SEQ_ALU_MUL_EN
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      count     <= '0;
`endif
    end else begin
      case (state)
        MUL: begin
`ifdef SEQ_ALU_MUL_EN
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count - CNT_ONE;
          // The last multiplier bit is folded in via acc_next on the same edge the result is registered.
          if (count == CNT_ONE) begin
            ALUResult <= acc_next;
            ALUFlag   <= {acc_next[WIDTH-1], acc_next == '0, 2'b00};
            Busy      <= 1'b0;
            Done      <= 1'b1;
            state     <= DONE;
          end
`else
          state <= IDLE;
`endif
        end
        default: begin
          if (accept && start_mul) begin
            state <= MUL;
            Busy  <= 1'b1;
            Done  <= 1'b0;
`ifdef SEQ_ALU_MUL_EN
            mcand  <= SrcA;
            mplier <= SrcB;
            acc    <= '0;
            count  <= CNT_INIT;
`endif
          end else if (accept) begin
            ALUResult <= res;
            ALUFlag   <= flags;
            Done      <= 1'b1;
            state     <= DONE;
          end else begin
            Done  <= 1'b0;
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: scoreboard bench for seq_alu; expected results are queued at issue and popped on Done.
// MUL timing checks are built only when SEQ_ALU_MUL_EN is defined.
module tb_seq_alu;
  localparam int WIDTH = 32;
`ifdef SEQ_ALU_MUL_EN
  localparam logic MUL_BUILT = 1'b1;
`else
  localparam logic MUL_BUILT = 1'b0;
`endif

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic [3:0]       flg;
  } exp_t;

  typedef struct {
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] res;
    logic [3:0]       flg;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [2:0]       alu_control;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] alu_result;
  logic [3:0]       alu_flag;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  seq_alu #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .Start     (start),
    .ALUControl(alu_control),
    .SrcA      (src_a),
    .SrcB      (src_b),
    .Busy      (busy),
    .Done      (done),
    .ALUResult (alu_result),
    .ALUFlag   (alu_flag)
  );

  always #5 clk = ~clk;

  // Reference model written independently of the RTL datapath.
  function automatic exp_t model(input logic [2:0] op, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    logic [WIDTH-1:0] r;
    logic c, v;
    int s;
    exp_t e;
    r = '0;
    c = 1'b0;
    v = 1'b0;
    s = int'(y[4:0]);
    case (op)
      3'b000: begin r = x + y; c = (r < x); v = (x[31] == y[31]) && (r[31] != x[31]); end
      3'b001: begin r = x - y; c = (x < y); v = (x[31] != y[31]) && (r[31] != x[31]); end
      3'b010: r = x & y;
      3'b011: r = x | y;
      3'b100: r = x ^ y;
      3'b101: begin r = x << s; if (s != 0) c = x[WIDTH - s]; end
      3'b110: begin r = x >> s; if (s != 0) c = x[s - 1]; end
`ifdef SEQ_ALU_MUL_EN
      3'b111: r = x * y;
`endif
      default: r = '0;
    endcase
    e.res = r;
    e.flg = {r[31], r == '0, c, v};
    return e;
  endfunction

  task automatic drive(input vec_t v);
    exp_t e;
    start       = 1'b1;
    alu_control = v.op;
    src_a       = v.a;
    src_b       = v.b;
    e.res       = v.res;
    e.flg       = v.flg;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    start       = 1'b0;
    alu_control = 3'b000;
    src_a       = '0;
    src_b       = '0;
    repeat (2) @(negedge clk);
    n_vec++; if (busy !== 1'b0) begin n_miss++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    n_vec++; if (done !== 1'b0) begin n_miss++; $display("[TB] FAIL reset_done: got %b want 0", done); end
    n_vec++; if (alu_result !== '0) begin n_miss++; $display("[TB] FAIL reset_result: got %h want 0", alu_result); end
    n_vec++; if (alu_flag !== 4'b0100) begin n_miss++; $display("[TB] FAIL reset_flag: got %b want 0100", alu_flag); end
    rst_n = 1'b1;
  endtask

  task automatic test_add_sub();
    vec_t v[3];
    exp_t e;
    v[0] = '{3'b000, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 4'b1001};
    v[1] = '{3'b001, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 4'b0100};
    v[2] = '{3'b001, 32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 4'b1010};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(v[i]);
      @(negedge clk);
      start = 1'b0;
      src_a = $urandom;
      n_vec++;
      if (done !== 1'b1 || busy !== 1'b0) begin
        n_miss++; $display("[TB] FAIL add_sub_done[%0d]: done=%b busy=%b want done=1 busy=0", i, done, busy);
      end
      e = sb.pop_front();
      n_vec++;
      if ({alu_result, alu_flag} !== e) begin
        n_miss++; $display("[TB] FAIL add_sub_result[%0d]: got %h/%b want %h/%b", i, alu_result, alu_flag, e.res, e.flg);
      end
      @(negedge clk);
      n_vec++;
      if (done !== 1'b0 || {alu_result, alu_flag} !== e) begin
        n_miss++; $display("[TB] FAIL add_sub_hold[%0d]: done=%b %h/%b want done=0 %h/%b", i, done, alu_result, alu_flag, e.res, e.flg);
      end
    end
  endtask

  task automatic test_shifts();
    vec_t v[6];
    exp_t e;
    v[0] = '{3'b101, 32'h8000_0001, 32'h0000_0001, 32'h0000_0002, 4'b0010};
    v[1] = '{3'b110, 32'h0000_0003, 32'h0000_0001, 32'h0000_0001, 4'b0010};
    v[2] = '{3'b101, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 4'b0000};
    v[3] = '{3'b110, 32'h8000_0000, 32'h0000_001F, 32'h0000_0001, 4'b0000};
    v[4] = '{3'b101, 32'h0000_0001, 32'h0000_001F, 32'h8000_0000, 4'b1000};
    v[5] = '{3'b101, 32'h4000_0000, 32'hFFFF_FFE1, 32'h8000_0000, 4'b1000};
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      drive(v[i]);
      @(negedge clk);
      e = sb.pop_front();
      n_vec++;
      if (done !== 1'b1 || {alu_result, alu_flag} !== e) begin
        n_miss++; $display("[TB] FAIL shift[%0d]: done=%b %h/%b want done=1 %h/%b", i, done, alu_result, alu_flag, e.res, e.flg);
      end
    end
    start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    vec_t v[5];
    exp_t e;
    int n;
    v[0] = '{3'b010, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 4'b1000};
    v[1] = '{3'b011, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 4'b1000};
    v[2] = '{3'b100, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 4'b0000};
    v[3] = '{3'b111, 32'hDEAD_BEEF, 32'h1234_5678, 32'h0000_0000, 4'b0100};
    v[4] = '{3'b000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b0110};
    n = MUL_BUILT ? 3 : 5;
    @(negedge clk);
    for (int i = 0; i < n; i++) begin
      drive(v[i]);
      @(negedge clk);
      e = sb.pop_front();
      n_vec++;
      if (done !== 1'b1 || busy !== 1'b0 || {alu_result, alu_flag} !== e) begin
        n_miss++; $display("[TB] FAIL b2b[%0d]: done=%b busy=%b %h/%b want done=1 busy=0 %h/%b", i, done, busy, alu_result, alu_flag, e.res, e.flg);
      end
    end
    start = 1'b0;
    @(negedge clk);
    n_vec++;
    if (done !== 1'b0 || {alu_result, alu_flag} !== e) begin
      n_miss++; $display("[TB] FAIL b2b_tail: done=%b %h/%b want done=0 %h/%b", done, alu_result, alu_flag, e.res, e.flg);
    end
  endtask

`ifdef SEQ_ALU_MUL_EN
  task automatic test_mul();
    vec_t v[3];
    exp_t e;
    exp_t prev;
    int bad;
    v[0] = '{3'b111, 32'h0001_0003, 32'h0000_0005, 32'h0005_000F, 4'b0000};
    v[1] = '{3'b111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 4'b0000};
    v[2] = '{3'b111, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 4'b0100};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      prev = {alu_result, alu_flag};
      drive(v[i]);
      bad = 0;
      for (int c = 1; c <= WIDTH; c++) begin
        @(negedge clk);
        alu_control = 3'b000;
        src_a = $urandom;
        src_b = $urandom;
        if (busy !== 1'b1 || done !== 1'b0 || {alu_result, alu_flag} !== prev) bad++;
      end
      n_vec++;
      if (bad != 0) begin n_miss++; $display("[TB] FAIL mul_busy_window[%0d]: bad cycles %0d want 0", i, bad); end
      @(negedge clk);
      start = 1'b0;
      e = sb.pop_front();
      n_vec++;
      if (done !== 1'b1 || busy !== 1'b0 || {alu_result, alu_flag} !== e) begin
        n_miss++; $display("[TB] FAIL mul_done[%0d]: done=%b busy=%b %h/%b want done=1 busy=0 %h/%b", i, done, busy, alu_result, alu_flag, e.res, e.flg);
      end
      @(negedge clk);
    end
  endtask
`endif

  task automatic test_random();
    vec_t v;
    exp_t e;
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      v.op = 3'($urandom_range(0, MUL_BUILT ? 6 : 7));
      v.a  = $urandom;
      v.b  = (i % 4 == 0) ? v.a : $urandom;
      e    = model(v.op, v.a, v.b);
      v.res = e.res;
      v.flg = e.flg;
      drive(v);
      @(negedge clk);
      e = sb.pop_front();
      n_vec++;
      if (done !== 1'b1 || {alu_result, alu_flag} !== e) begin
        n_miss++; $display("[TB] FAIL random[%0d] op=%0d a=%h b=%h: done=%b %h/%b want done=1 %h/%b", i, v.op, v.a, v.b, done, alu_result, alu_flag, e.res, e.flg);
      end
    end
    start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_mul();
    exp_t e;
    @(negedge clk);
    start = 1'b1; alu_control = 3'b111; src_a = 32'd7; src_b = 32'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    n_vec++;
    if (busy !== MUL_BUILT) begin n_miss++; $display("[TB] FAIL mid_mul_busy: got %b want %b", busy, MUL_BUILT); end
    rst_n = 1'b0;
    #1;
    n_vec++; if (busy !== 1'b0) begin n_miss++; $display("[TB] FAIL abort_busy: got %b want 0", busy); end
    n_vec++; if (done !== 1'b0) begin n_miss++; $display("[TB] FAIL abort_done: got %b want 0", done); end
    n_vec++; if (alu_result !== '0) begin n_miss++; $display("[TB] FAIL abort_result: got %h want 0", alu_result); end
    n_vec++; if (alu_flag !== 4'b0100) begin n_miss++; $display("[TB] FAIL abort_flag: got %b want 0100", alu_flag); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    drive('{3'b000, 32'd1, 32'd1, 32'd2, 4'b0000});
    @(negedge clk);
    start = 1'b0;
    e = sb.pop_front();
    n_vec++;
    if (done !== 1'b1 || {alu_result, alu_flag} !== e) begin
      n_miss++; $display("[TB] FAIL post_reset_add: done=%b %h/%b want done=1 %h/%b", done, alu_result, alu_flag, e.res, e.flg);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_shifts();
    test_back_to_back();
`ifdef SEQ_ALU_MUL_EN
    test_mul();
`endif
    test_random();
    test_reset_mid_mul();
    n_vec++;
    if (sb.size() != 0) begin n_miss++; $display("[TB] FAIL scoreboard_drain: %0d left want 0", sb.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
